// File: rtl/vga_out_pkg.sv
// vga_out_pkg: mode encodings, colour-bar table and CRC constants for the VGA output stage
package vga_out_pkg;
    localparam logic [1:0] MODE_PASS   = 2'd0;
    localparam logic [1:0] MODE_BORDER = 2'd1;
    localparam logic [1:0] MODE_BARS   = 2'd2;
    localparam logic [1:0] MODE_SOLID  = 2'd3;
    // {R,G,B} masks; index 0 is the leftmost bar (white) through 7 (black)
    localparam logic [7:0][2:0] BAR_RGB = {3'b000, 3'b001, 3'b100, 3'b101,
                                           3'b010, 3'b011, 3'b110, 3'b111};
    localparam logic [15:0] CRC_POLY = 16'h1021;
    localparam logic [15:0] CRC_INIT = 16'hFFFF;
endpackage

// File: rtl/vga_out_stage_if.sv
// vga_out_stage_if: pixel/timing bus from the timing generator and pixel source into the output stage
interface vga_out_stage_if #(
    parameter int COLOR_W = 4,
    parameter int X_W     = 10,
    parameter int Y_W     = 9
);
    logic               SYNC_COLOR;
    logic               iHS;
    logic               iVS;
    logic [X_W-1:0]     Current_X;
    logic [Y_W-1:0]     Current_Y;
    logic [COLOR_W-1:0] iVGA_R;
    logic [COLOR_W-1:0] iVGA_G;
    logic [COLOR_W-1:0] iVGA_B;
    modport master (output SYNC_COLOR, iHS, iVS, Current_X, Current_Y, iVGA_R, iVGA_G, iVGA_B);
    modport slave  (input  SYNC_COLOR, iHS, iVS, Current_X, Current_Y, iVGA_R, iVGA_G, iVGA_B);
endinterface

// File: rtl/vga_delay_line.sv
// vga_delay_line: DEPTH-stage shift register with async active-low reset to RST_VAL
module vga_delay_line #(
    parameter int             W       = 1,
    parameter int             DEPTH   = 1,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         VGA_CLK,
    input  logic         RESET,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);
    logic [DEPTH-1:0][W-1:0] r_sr;
    // shift one stage per clock; reset flushes every stage to the idle value
    always_ff @(posedge VGA_CLK or negedge RESET) begin
        if (!RESET) begin
            r_sr <= {DEPTH{RST_VAL}};
        end else begin
            for (int i = DEPTH - 1; i > 0; i--) r_sr[i] <= r_sr[i-1];
            r_sr[0] <= i_d;
        end
    end
    assign o_q = r_sr[DEPTH-1];
endmodule

// File: rtl/vga_out_stage.sv
// vga_out_stage: visible-window gating, test patterns and aligned sync delay; VGA_OUT_CRC_EN adds a per-frame output CRC
module vga_out_stage import vga_out_pkg::*; #(
    parameter int COLOR_W    = 4,
    parameter int X_W        = 10,
    parameter int Y_W        = 9,
    parameter int X_START    = 1,
    parameter int Y_START    = 1,
    parameter int H_ACTIVE   = 640,
    parameter int V_ACTIVE   = 480,
    parameter int PIPE_DEPTH = 2,
    parameter bit SYNC_POL   = 1'b0
) (
    input  logic               VGA_CLK,
    input  logic               RESET,
    vga_out_stage_if.slave     pix,
    input  logic [1:0]         MODE,
    output logic [COLOR_W-1:0] oVGA_R,
    output logic [COLOR_W-1:0] oVGA_G,
    output logic [COLOR_W-1:0] oVGA_B,
    output logic               oHS,
    output logic               oVS,
    output logic               oDE,
    output logic [7:0]         oFRAME_CNT,
    output logic [15:0]        oCRC
);
    localparam int BAR_W = H_ACTIVE / 8;
    localparam int CNT_W = BAR_W > 1 ? $clog2(BAR_W) : 1;
    localparam int X_END = X_START + H_ACTIVE - 1;
    localparam int Y_END = Y_START + V_ACTIVE - 1;
    localparam int DW    = 3 * COLOR_W;
    localparam logic [COLOR_W-1:0] MID = COLOR_W'(1) << (COLOR_W - 1);

    logic             w_vis;
    logic             w_vs_act;
    logic             w_frame_start;
    logic             w_border;
    logic [2:0]       w_bar_mask;
    logic [DW-1:0]    w_in_rgb;
    logic [DW-1:0]    w_bar_rgb;
    logic [DW-1:0]    w_s1_rgb;
    logic [DW-1:0]    w_out_rgb;
    logic             r_vs_act;
    logic [1:0]       r_mode;
    logic [CNT_W-1:0] r_col_cnt;
    logic [2:0]       r_bar_idx;

    assign w_vis = pix.SYNC_COLOR && pix.Current_X >= X_W'(X_START) && pix.Current_Y >= Y_W'(Y_START);
    assign w_vs_act = pix.iVS == SYNC_POL;
    assign w_frame_start = w_vs_act && !r_vs_act;
    assign w_border = pix.Current_X == X_W'(X_START) || pix.Current_X == X_W'(X_END)
                   || pix.Current_Y == Y_W'(Y_START) || pix.Current_Y == Y_W'(Y_END);
    assign w_in_rgb = {pix.iVGA_R, pix.iVGA_G, pix.iVGA_B};
    assign w_bar_mask = BAR_RGB[r_bar_idx];
    assign w_bar_rgb = {{COLOR_W{w_bar_mask[2]}}, {COLOR_W{w_bar_mask[1]}}, {COLOR_W{w_bar_mask[0]}}};

    // frame-start edge history (starts "active" so a sync already asserted at reset is not a frame start),
    // mode latch and debug frame counter
    always_ff @(posedge VGA_CLK or negedge RESET) begin
        if (!RESET) begin
            r_vs_act   <= 1'b1;
            r_mode     <= MODE_PASS;
            oFRAME_CNT <= '0;
        end else begin
            r_vs_act <= w_vs_act;
            if (w_frame_start) begin
                r_mode     <= MODE;
                oFRAME_CNT <= oFRAME_CNT + 8'd1;
            end
        end
    end

    // bar position tracking; cleared whenever blanked so every line starts at bar 0
    always_ff @(posedge VGA_CLK or negedge RESET) begin
        if (!RESET) begin
            r_col_cnt <= '0;
            r_bar_idx <= '0;
        end else if (!w_vis) begin
            r_col_cnt <= '0;
            r_bar_idx <= '0;
        end else if (r_col_cnt == CNT_W'(BAR_W - 1)) begin
            r_col_cnt <= '0;
            r_bar_idx <= r_bar_idx == 3'd7 ? 3'd7 : r_bar_idx + 3'd1;
        end else begin
            r_col_cnt <= r_col_cnt + 1'b1;
        end
    end

    // stage-1 pattern select, forced to black outside the visible window
    always_comb begin
        w_s1_rgb = r_mode == MODE_BORDER ? (w_border ? '1 : w_in_rgb)
                 : r_mode == MODE_BARS   ? w_bar_rgb
                 : r_mode == MODE_SOLID  ? {3{MID}}
                 : w_in_rgb;
        w_s1_rgb = w_vis ? w_s1_rgb : '0;
    end

    vga_delay_line #(.W(DW), .DEPTH(PIPE_DEPTH), .RST_VAL('0)) u_rgb_dly (
        .VGA_CLK (VGA_CLK),
        .RESET   (RESET),
        .i_d     (w_s1_rgb),
        .o_q     (w_out_rgb)
    );

    vga_delay_line #(.W(3), .DEPTH(PIPE_DEPTH), .RST_VAL({~SYNC_POL, ~SYNC_POL, 1'b0})) u_sync_dly (
        .VGA_CLK (VGA_CLK),
        .RESET   (RESET),
        .i_d     ({pix.iHS, pix.iVS, w_vis}),
        .o_q     ({oHS, oVS, oDE})
    );

    assign {oVGA_R, oVGA_G, oVGA_B} = w_out_rgb;

`ifdef VGA_OUT_CRC_EN
    logic        r_ovs_act;
    logic [15:0] r_crc;

    function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [DW-1:0] d);
        for (int i = DW - 1; i >= 0; i--) c = (c[15] ^ d[i]) ? ((c << 1) ^ CRC_POLY) : (c << 1);
        return c;
    endfunction

    // CRC over displayed pixels, published and restarted on each output-side frame start
    always_ff @(posedge VGA_CLK or negedge RESET) begin
        if (!RESET) begin
            r_ovs_act <= 1'b1;
            r_crc     <= CRC_INIT;
            oCRC      <= '0;
        end else begin
            r_ovs_act <= oVS == SYNC_POL;
            if (oVS == SYNC_POL && !r_ovs_act) begin
                oCRC  <= r_crc;
                r_crc <= CRC_INIT;
            end else if (oDE) begin
                r_crc <= crc_step(r_crc, w_out_rgb);
            end
        end
    end
`else
    assign oCRC = 16'h0000;
`endif
endmodule

// File: tb/tb_vga_out_stage.sv
// tb_vga_out_stage: directed checks of gating, patterns, alignment, frame counter and reset
module tb_vga_out_stage;
    logic        VGA_CLK = 1'b0;
    logic        RESET = 1'b0;
    logic [1:0]  MODE = 2'd0;
    logic [3:0]  oVGA_R, oVGA_G, oVGA_B;
    logic        oHS, oVS, oDE;
    logic [7:0]  oFRAME_CNT;
    logic [15:0] oCRC;
    logic [11:0] o_rgb;
    int          errors = 0;
    int          checks = 0;
    logic [11:0] bar_exp [8] = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0, 12'hF0F, 12'hF00, 12'h00F, 12'h000};

    vga_out_stage_if #(.COLOR_W(4), .X_W(10), .Y_W(9)) pix ();

    vga_out_stage dut (
        .VGA_CLK    (VGA_CLK),
        .RESET      (RESET),
        .pix        (pix),
        .MODE       (MODE),
        .oVGA_R     (oVGA_R),
        .oVGA_G     (oVGA_G),
        .oVGA_B     (oVGA_B),
        .oHS        (oHS),
        .oVS        (oVS),
        .oDE        (oDE),
        .oFRAME_CNT (oFRAME_CNT),
        .oCRC       (oCRC)
    );

    assign o_rgb = {oVGA_R, oVGA_G, oVGA_B};

    always #5 VGA_CLK = ~VGA_CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge VGA_CLK);
        #1;
    endtask

    task automatic drive(input logic de, input logic hs, input logic vs, input int x, input int y, input logic [11:0] rgb);
        pix.SYNC_COLOR = de;
        pix.iHS = hs;
        pix.iVS = vs;
        pix.Current_X = 10'(x);
        pix.Current_Y = 9'(y);
        {pix.iVGA_R, pix.iVGA_G, pix.iVGA_B} = rgb;
    endtask

    task automatic frame_start(input logic [1:0] m);
        MODE = m;
        drive(1'b0, 1'b1, 1'b0, 0, 0, 12'h000);
        tick(1);
        drive(1'b0, 1'b1, 1'b1, 0, 0, 12'h000);
        tick(1);
    endtask

    task automatic pix_chk(input string tag, input int x, input int y, input logic [11:0] rgb, input logic [11:0] exp);
        drive(1'b1, 1'b1, 1'b1, x, y, rgb);
        tick(2);
        check(tag, o_rgb, exp);
    endtask

`ifdef VGA_OUT_CRC_EN
    function automatic logic [15:0] crc_ref(input logic [15:0] c, input logic [11:0] d);
        for (int i = 11; i >= 0; i--) c = (c[15] ^ d[i]) ? ((c << 1) ^ 16'h1021) : (c << 1);
        return c;
    endfunction
`endif

    initial begin
        int bad [8];
        logic [15:0] ref_crc;
        drive(1'b0, 1'b1, 1'b1, 0, 0, 12'h000);
        tick(3);
        check("rst_rgb", o_rgb, 12'h000);
        check("rst_hs", oHS, 1'b1);
        check("rst_vs", oVS, 1'b1);
        check("rst_de", oDE, 1'b0);
        check("rst_fcnt", oFRAME_CNT, 8'd0);
        RESET = 1'b1;
        tick(1);
        check("rel_rgb", o_rgb, 12'h000);
        check("rel_de", oDE, 1'b0);

        drive(1'b1, 1'b0, 1'b1, 5, 5, 12'hA53);
        tick(1);
        check("pass_lat1_de", oDE, 1'b0);
        tick(1);
        check("pass_rgb", o_rgb, 12'hA53);
        check("pass_de", oDE, 1'b1);
        check("pass_hs", oHS, 1'b0);
        drive(1'b1, 1'b1, 1'b1, 0, 5, 12'hA53);
        tick(2);
        check("x0_rgb", o_rgb, 12'h000);
        check("x0_de", oDE, 1'b0);
        pix_chk("y0_rgb", 5, 0, 12'hA53, 12'h000);
        check("fcnt_nofs", oFRAME_CNT, 8'd0);

        frame_start(2'd2);
        check("fcnt_1", oFRAME_CNT, 8'd1);
        foreach (bad[b]) bad[b] = 0;
        for (int x = 0; x <= 641; x++) begin
            drive(x >= 1 && x <= 640, 1'b1, 1'b1, x, 5, 12'h123);
            tick(1);
            if (x - 1 >= 1 && x - 1 <= 640 && o_rgb !== bar_exp[(x - 2) / 80]) bad[(x - 2) / 80]++;
        end
        foreach (bad[b]) check($sformatf("bar%0d_bad_pixels", b), bad[b], 0);

        frame_start(2'd0);
        check("fcnt_2", oFRAME_CNT, 8'd2);
        MODE = 2'd1;
        pix_chk("mid_switch_pass", 1, 5, 12'h123, 12'h123);
        frame_start(2'd1);
        pix_chk("border_left", 1, 5, 12'h123, 12'hFFF);
        pix_chk("border_bottom", 2, 480, 12'h123, 12'hFFF);
        pix_chk("border_right", 640, 100, 12'h123, 12'hFFF);
        pix_chk("border_top", 2, 1, 12'h123, 12'hFFF);
        pix_chk("border_inner", 100, 100, 12'h123, 12'h123);
        pix_chk("border_inner_corner", 639, 479, 12'h456, 12'h456);

        frame_start(2'd3);
        pix_chk("solid", 100, 100, 12'h123, 12'h888);
        pix_chk("solid_blank", 100, 0, 12'h123, 12'h000);
        check("fcnt_4", oFRAME_CNT, 8'd4);
        for (int i = 0; i < 251; i++) frame_start(2'd3);
        check("fcnt_255", oFRAME_CNT, 8'd255);
        frame_start(2'd3);
        check("fcnt_wrap", oFRAME_CNT, 8'd0);

        pix_chk("solid_pre_rst", 50, 50, 12'h456, 12'h888);
        #2 RESET = 1'b0;
        #1;
        check("async_rst_rgb", o_rgb, 12'h000);
        check("async_rst_de", oDE, 1'b0);
        check("async_rst_vs", oVS, 1'b1);
        check("async_rst_fcnt", oFRAME_CNT, 8'd0);
        tick(1);
        RESET = 1'b1;
        pix_chk("pass_after_rst", 50, 50, 12'h456, 12'h456);

`ifdef VGA_OUT_CRC_EN
        ref_crc = 16'hFFFF;
        for (int i = 0; i < 10; i++) ref_crc = crc_ref(ref_crc, 12'h5A3);
        frame_start(2'd0);
        for (int f = 0; f < 2; f++) begin
            for (int x = 1; x <= 10; x++) begin
                drive(1'b1, 1'b1, 1'b1, x, 1, 12'h5A3);
                tick(1);
            end
            frame_start(2'd0);
            tick(3);
            check($sformatf("crc_frame%0d", f), oCRC, ref_crc);
        end
`else
        ref_crc = 16'h0000;
        check("crc_tied", oCRC, ref_crc);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/vga_out_stage.md
Name: vga_out_stage

Overview:
Parametrised VGA pixel output stage sitting between the pixel source and the DAC/pins. It gates colour to the visible window and inserts built-in test patterns (border, colour bars, solid). It delays HS/VS/DE through the same pipeline as colour, so all outputs leave aligned. A frame counter is provided for debug.

Parameters:
COLOR_W, 4, bits per colour channel
X_W, 10, width of Current_X
Y_W, 9, width of Current_Y
X_START, 1, first visible column (columns below it are blanked)
Y_START, 1, first visible row
H_ACTIVE, 640, visible width in pixels; must be a multiple of 8
V_ACTIVE, 480, visible height in lines
PIPE_DEPTH, 2, total latency in clocks from inputs to outputs; must be >= 1
SYNC_POL, 0, active level of iHS/iVS and oHS/oVS

Ports:
VGA_CLK  in  1  pixel clock
RESET  in  1  asynchronous, active-low reset
SYNC_COLOR  in  1  display-enable from timing generator
iHS  in  1  horizontal sync from timing generator
iVS  in  1  vertical sync from timing generator
Current_X  in  X_W  current column
Current_Y  in  Y_W  current row
iVGA_R/iVGA_G/iVGA_B  in  COLOR_W each  source pixel colour
MODE  in  2  0=pass, 1=border, 2=colour bars, 3=solid mid-grey
oVGA_R/oVGA_G/oVGA_B  out  COLOR_W each  output colour
oHS, oVS  out  1 each  delayed syncs
oDE  out  1  delayed visible flag
oFRAME_CNT  out  8  frame counter
oCRC  out  16  per-frame output CRC (see Optional Feature)

Behaviour:
- Reset (RESET low, async): all colour outputs 0; oHS/oVS = ~SYNC_POL (inactive); oDE 0; oFRAME_CNT 0; latched mode 0; bar counters 0; all pipeline registers cleared to these same values.
- Visible: vis = SYNC_COLOR && Current_X >= X_START && Current_Y >= Y_START. When vis = 0, colour is 0 regardless of mode.
- Frame start: first clock where iVS equals SYNC_POL after a clock where it did not (registered edge detect).
  - On frame start, MODE is latched into mode_q and oFRAME_CNT increments, wrapping 255 -> 0.
  - MODE changes mid-frame take effect only at the next frame start.
- Pattern select, stage 1 (mode_q):
  - pass: output = iVGA colour.
  - border: white (all channels all-ones) when X == X_START, X == X_START+H_ACTIVE-1, Y == Y_START or Y == Y_START+V_ACTIVE-1; otherwise input colour.
  - bars: 8 vertical bars, each BAR_W = H_ACTIVE/8 wide, in order white, yellow, cyan, green, magenta, red, blue, black. Channels are all-ones or 0.
  - solid: each channel = MSB set, rest 0 (0x8 for COLOR_W=4).
- Bar counters: col_cnt counts 0..BAR_W-1 while vis; bar_idx increments when col_cnt wraps and saturates at 7. Both clear on any clock with vis = 0, so they re-align every line.
- Alignment: the stage-1 result plus iHS, iVS and vis pass through PIPE_DEPTH-1 further register stages. Total latency is exactly PIPE_DEPTH clocks for every output.
- Reset mid-frame: the pipeline flushes to reset values. Output stays in pass mode until the first frame start after reset release.

Optional Feature:
Macro VGA_OUT_CRC_EN.
- Defined: CRC-16-CCITT (poly 0x1021, init 0xFFFF) accumulates over {R,G,B} of every output pixel with oDE = 1. On the output-side frame start, the accumulated value is copied to oCRC and the accumulator re-inits. oCRC resets to 0.
- Not defined: oCRC tied to 16'h0000 and no CRC logic is generated.

Decomposition:
- Package vga_out_pkg holds:
  - the mode encoding constants (MODE_PASS=0, MODE_BORDER=1, MODE_BARS=2, MODE_SOLID=3);
  - the 8-entry bar colour table as 3-bit RGB masks;
  - the CRC polynomial and init constants.
- Sub-module vga_delay_line: parametrised width/depth shift register with async active-low reset and a per-instance reset value. It is instantiated for colour and for the sync/DE bundle.

Test Plan:
- Reset held low, toggle clock -> all colours 0, oHS=oVS=1, oDE=0, oFRAME_CNT=0. Release reset -> values unchanged until inputs propagate.
- MODE=0, PIPE_DEPTH=2, pixel X=5,Y=5, SYNC_COLOR=1, RGB=A/5/3 -> output A/5/3 with oDE=1 exactly 2 clocks later. Same pixel at X=0 -> 0/0/0 with oDE=0.
- MODE=2 latched at frame start, full 640-pixel line -> output 8 runs of 80 pixels: F/F/F, F/F/0, 0/F/F, 0/F/0, F/0/F, F/0/0, 0/0/F, 0/0/0.
- MODE switched 0->1 mid-frame -> still pass colour until next iVS edge; then X=1 column and Y=480 row white, interior = input.
- 256 frame starts -> oFRAME_CNT reaches 255 then wraps to 0. Async reset asserted mid-line -> outputs 0 in the same cycle.
- With VGA_OUT_CRC_EN, constant colour frame -> oCRC equals the reference-model CRC after the next frame start and is repeated identically every frame.
